// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forward-select codes, FSM states and the
// hard-wired zero register tag.
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam int REG_ZERO = 0;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_sel.sv
// Priority forward select for one source operand: EX/MEM beats MEM/WB beats the
// register file. Register 0 never matches.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] exmem_rd_i,
    input  logic             exmem_wr_i,
    input  logic [REG_W-1:0] memwb_rd_i,
    input  logic             memwb_wr_i,
    output logic [1:0]       sel_o
);

    logic src_nz;

    assign src_nz = (src_i != REG_W'(REG_ZERO));

    always_comb begin
        sel_o = FWD_RF;
        if (src_nz && exmem_wr_i && (src_i == exmem_rd_i)) begin
            sel_o = FWD_EXMEM;
        end else if (src_nz && memwb_wr_i && (src_i == memwb_rd_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding, stall/flush sequencing and stall watchdog for the 5-stage pipeline.
// Optional perf counters (Stall_Cnt, Flush_Cnt) are built when HAZ_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | evaluate stall need each cycle; Stall = (need > 0)
// HOLD  | second cycle of a load-then-branch stall; inputs ignored
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int MAX_STALL = 2
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W   = 32
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] IfId_Rs,
    input  logic [REG_W-1:0] IfId_Rt,
    input  logic [REG_W-1:0] IdEx_Rs,
    input  logic [REG_W-1:0] IdEx_Rt,
    input  logic [REG_W-1:0] IdEx_Rd,
    input  logic             IdEx_MemRead,
    input  logic             IdEx_RegWrite,
    input  logic [REG_W-1:0] ExMem_Rd,
    input  logic             ExMem_Reg_Wr_Control,
    input  logic             ExMem_MemRead,
    input  logic [REG_W-1:0] MemWb_Rd,
    input  logic             MemWb_Reg_Wr_Control,
    input  logic             Ctrl_Branch,
    input  logic             Br_Taken,
    output logic [1:0]       FwdRs,
    output logic [1:0]       FwdRt,
    output logic [1:0]       Fwd_IfId_Rs,
    output logic [1:0]       Fwd_IfId_Rt,
    output logic             Stall,
    output logic             Flush,
    output logic             FwdPc,
    output logic             Haz_Err
`ifdef HAZ_PERF_CNT_EN
    , output logic [CNT_W-1:0] Stall_Cnt
    , output logic [CNT_W-1:0] Flush_Cnt
`endif
);

    localparam int              WD_W   = $clog2(MAX_STALL + 2);
    localparam logic [WD_W-1:0] WD_SAT = WD_W'(MAX_STALL + 1);

    function automatic logic tag_hit(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst,
                                     input logic             wr_en);
        return wr_en && (src == dst) && (dst != REG_W'(REG_ZERO));
    endfunction

    logic [1:0]      fwd_rs, fwd_rt, fwd_id_rs, fwd_id_rt;
    logic            id_exmem_wr;
    logic            ld_hit, ex_hit, mem_ld_hit;
    logic [1:0]      stall_need;
    logic            stall_raw, branch_go;
    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            haz_err_q, haz_err_d;

    // A load in MEM has no data yet, so the branch comparator cannot take it from EX/MEM.
    assign id_exmem_wr = ExMem_Reg_Wr_Control & ~ExMem_MemRead;

    fwd_sel #(.REG_W(REG_W)) u_ex_rs (
        .src_i(IdEx_Rs), .exmem_rd_i(ExMem_Rd), .exmem_wr_i(ExMem_Reg_Wr_Control),
        .memwb_rd_i(MemWb_Rd), .memwb_wr_i(MemWb_Reg_Wr_Control), .sel_o(fwd_rs));
    fwd_sel #(.REG_W(REG_W)) u_ex_rt (
        .src_i(IdEx_Rt), .exmem_rd_i(ExMem_Rd), .exmem_wr_i(ExMem_Reg_Wr_Control),
        .memwb_rd_i(MemWb_Rd), .memwb_wr_i(MemWb_Reg_Wr_Control), .sel_o(fwd_rt));
    fwd_sel #(.REG_W(REG_W)) u_id_rs (
        .src_i(IfId_Rs), .exmem_rd_i(ExMem_Rd), .exmem_wr_i(id_exmem_wr),
        .memwb_rd_i(MemWb_Rd), .memwb_wr_i(MemWb_Reg_Wr_Control), .sel_o(fwd_id_rs));
    fwd_sel #(.REG_W(REG_W)) u_id_rt (
        .src_i(IfId_Rt), .exmem_rd_i(ExMem_Rd), .exmem_wr_i(id_exmem_wr),
        .memwb_rd_i(MemWb_Rd), .memwb_wr_i(MemWb_Reg_Wr_Control), .sel_o(fwd_id_rt));

    assign ld_hit     = tag_hit(IfId_Rs, IdEx_Rd, IdEx_MemRead)
                      | tag_hit(IfId_Rt, IdEx_Rd, IdEx_MemRead);
    assign ex_hit     = tag_hit(IfId_Rs, IdEx_Rd, IdEx_RegWrite & ~IdEx_MemRead)
                      | tag_hit(IfId_Rt, IdEx_Rd, IdEx_RegWrite & ~IdEx_MemRead);
    assign mem_ld_hit = tag_hit(IfId_Rs, ExMem_Rd, ExMem_MemRead)
                      | tag_hit(IfId_Rt, ExMem_Rd, ExMem_MemRead);

    always_comb begin
        stall_need = 2'd0;
        if (Ctrl_Branch && ld_hit) begin
            stall_need = 2'd2;
        end else if (ld_hit || (Ctrl_Branch && (ex_hit || mem_ld_hit))) begin
            stall_need = 2'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            wd_cnt_q  <= '0;
            haz_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_cnt_q  <= wd_cnt_d;
            haz_err_q <= haz_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                stall_raw = (stall_need != 2'd0);
                if (stall_need == 2'd2) state_d = HOLD;
            end
            HOLD: begin
                stall_raw = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign branch_go = ~stall_raw & Ctrl_Branch & Br_Taken;

    // Counter saturates at WD_SAT, so reaching it is the "exceeded MAX_STALL" event.
    always_comb begin
        wd_cnt_d = '0;
        if (stall_raw) begin
            wd_cnt_d = (wd_cnt_q == WD_SAT) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
        haz_err_d = haz_err_q | (wd_cnt_d == WD_SAT);
    end

    // Outputs are forced quiet while reset is held, including the combinational paths.
    assign FwdRs       = RST ? FWD_RF : fwd_rs;
    assign FwdRt       = RST ? FWD_RF : fwd_rt;
    assign Fwd_IfId_Rs = RST ? FWD_RF : fwd_id_rs;
    assign Fwd_IfId_Rt = RST ? FWD_RF : fwd_id_rt;
    assign Stall       = stall_raw & ~RST;
    assign Flush       = branch_go & ~RST;
    assign FwdPc       = branch_go & ~RST;
    assign Haz_Err     = haz_err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (Flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: expected output vectors are queued as stimulus is
// driven and popped for comparison at the following falling edge.
module tb_hazard_unit;

    logic       CLK, RST;
    logic [4:0] IfId_Rs, IfId_Rt, IdEx_Rs, IdEx_Rt, IdEx_Rd, ExMem_Rd, MemWb_Rd;
    logic       IdEx_MemRead, IdEx_RegWrite, ExMem_Reg_Wr_Control, ExMem_MemRead;
    logic       MemWb_Reg_Wr_Control, Ctrl_Branch, Br_Taken;
    logic [1:0] FwdRs, FwdRt, Fwd_IfId_Rs, Fwd_IfId_Rt;
    logic       Stall, Flush, FwdPc, Haz_Err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] Stall_Cnt, Flush_Cnt;
`endif

    hazard_unit dut (
        .CLK(CLK), .RST(RST),
        .IfId_Rs(IfId_Rs), .IfId_Rt(IfId_Rt),
        .IdEx_Rs(IdEx_Rs), .IdEx_Rt(IdEx_Rt), .IdEx_Rd(IdEx_Rd),
        .IdEx_MemRead(IdEx_MemRead), .IdEx_RegWrite(IdEx_RegWrite),
        .ExMem_Rd(ExMem_Rd), .ExMem_Reg_Wr_Control(ExMem_Reg_Wr_Control),
        .ExMem_MemRead(ExMem_MemRead),
        .MemWb_Rd(MemWb_Rd), .MemWb_Reg_Wr_Control(MemWb_Reg_Wr_Control),
        .Ctrl_Branch(Ctrl_Branch), .Br_Taken(Br_Taken),
        .FwdRs(FwdRs), .FwdRt(FwdRt), .Fwd_IfId_Rs(Fwd_IfId_Rs), .Fwd_IfId_Rt(Fwd_IfId_Rt),
        .Stall(Stall), .Flush(Flush), .FwdPc(FwdPc), .Haz_Err(Haz_Err)
`ifdef HAZ_PERF_CNT_EN
        , .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [11:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    logic [11:0] obs;
    assign obs = {FwdRs, FwdRt, Fwd_IfId_Rs, Fwd_IfId_Rt, Stall, Flush, FwdPc, Haz_Err};

    // Order: FwdRs FwdRt Fwd_IfId_Rs Fwd_IfId_Rt Stall Flush FwdPc Haz_Err
    function automatic logic [11:0] pk(input logic [1:0] fr, input logic [1:0] ft,
                                       input logic [1:0] fir, input logic [1:0] fit,
                                       input logic st, input logic fl,
                                       input logic pc, input logic er);
        return {fr, ft, fir, fit, st, fl, pc, er};
    endfunction

    task automatic clr();
        IfId_Rs = 0; IfId_Rt = 0; IdEx_Rs = 0; IdEx_Rt = 0; IdEx_Rd = 0;
        ExMem_Rd = 0; MemWb_Rd = 0;
        IdEx_MemRead = 0; IdEx_RegWrite = 0; ExMem_Reg_Wr_Control = 0; ExMem_MemRead = 0;
        MemWb_Reg_Wr_Control = 0; Ctrl_Branch = 0; Br_Taken = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            @(posedge CLK); #1; clr();
            if (s == 0) begin
                RST = 1;
                IdEx_Rs = 5; ExMem_Rd = 5; ExMem_Reg_Wr_Control = 1;
                IfId_Rs = 3; IdEx_Rd = 3; IdEx_MemRead = 1; IdEx_RegWrite = 1;
                Ctrl_Branch = 1; Br_Taken = 1;
                sb.push_back('{"reset_held", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)});
            end else begin
                RST = 0;
                sb.push_back('{"reset_release", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)});
            end
            @(negedge CLK); e = sb.pop_front(); n_cmp++;
            if (obs !== e.v) begin
                n_mis++; $display("FAIL %s: got %b want %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_ex_fwd();
        exp_t e;
        for (int s = 0; s < 5; s++) begin
            @(posedge CLK); #1; clr();
            case (s)
                0: begin
                    ExMem_Rd = 5; ExMem_Reg_Wr_Control = 1; MemWb_Rd = 5; MemWb_Reg_Wr_Control = 1;
                    IdEx_Rs = 5; IfId_Rs = 5;
                    sb.push_back('{"ex_fwd_both_exmem_wins", pk(2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0)});
                end
                1: begin
                    ExMem_Rd = 5; MemWb_Rd = 5; MemWb_Reg_Wr_Control = 1;
                    IdEx_Rs = 5; IfId_Rs = 5;
                    sb.push_back('{"ex_fwd_memwb", pk(2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0)});
                end
                2: begin
                    ExMem_Reg_Wr_Control = 1; MemWb_Reg_Wr_Control = 1;
                    IdEx_Rs = 7;
                    sb.push_back('{"ex_fwd_r0_never", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)});
                end
                3: begin
                    ExMem_Rd = 9; ExMem_Reg_Wr_Control = 1; ExMem_MemRead = 1;
                    MemWb_Rd = 4; MemWb_Reg_Wr_Control = 1;
                    IdEx_Rs = 4; IdEx_Rt = 9; IfId_Rs = 4; IfId_Rt = 9;
                    sb.push_back('{"id_fwd_no_exmem_on_load", pk(2'b01, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0)});
                end
                default: begin
                    ExMem_Rd = 9; ExMem_Reg_Wr_Control = 1; ExMem_MemRead = 1;
                    MemWb_Rd = 9; MemWb_Reg_Wr_Control = 1;
                    IdEx_Rt = 9; IfId_Rt = 9;
                    sb.push_back('{"id_fwd_falls_to_memwb", pk(2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 0, 0)});
                end
            endcase
            @(negedge CLK); e = sb.pop_front(); n_cmp++;
            if (obs !== e.v) begin
                n_mis++; $display("FAIL %s: got %b want %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            @(posedge CLK); #1; clr();
            if (s == 0) begin
                IdEx_MemRead = 1; IdEx_RegWrite = 1; IdEx_Rd = 8; IfId_Rt = 8;
                sb.push_back('{"load_use_stall", pk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0)});
            end else begin
                MemWb_Rd = 8; MemWb_Reg_Wr_Control = 1; IdEx_Rt = 8;
                sb.push_back('{"load_use_fwd_after", pk(2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0)});
            end
            @(negedge CLK); e = sb.pop_front(); n_cmp++;
            if (obs !== e.v) begin
                n_mis++; $display("FAIL %s: got %b want %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_load_branch();
        exp_t e;
        for (int s = 0; s < 6; s++) begin
            @(posedge CLK); #1; clr();
            Ctrl_Branch = 1; Br_Taken = 1;
            case (s)
                0, 3: begin
                    IdEx_MemRead = 1; IdEx_RegWrite = 1; IdEx_Rd = 3; IfId_Rs = 3;
                    sb.push_back('{"ld_br_stall1", pk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0)});
                end
                1: begin
                    ExMem_Rd = 3; ExMem_Reg_Wr_Control = 1; ExMem_MemRead = 1; IfId_Rs = 3;
                    sb.push_back('{"ld_br_hold", pk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0)});
                end
                2: begin
                    MemWb_Rd = 3; MemWb_Reg_Wr_Control = 1; IfId_Rs = 3;
                    sb.push_back('{"ld_br_resolve", pk(2'b00, 2'b00, 2'b01, 2'b00, 0, 1, 1, 0)});
                end
                4: sb.push_back('{"hold_ignores_inputs", pk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0)});
                default: sb.push_back('{"idle_after_hold", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0)});
            endcase
            @(negedge CLK); e = sb.pop_front(); n_cmp++;
            if (obs !== e.v) begin
                n_mis++; $display("FAIL %s: got %b want %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        for (int s = 0; s < 5; s++) begin
            @(posedge CLK); #1; clr();
            case (s)
                0: begin
                    Ctrl_Branch = 1; Br_Taken = 1;
                    sb.push_back('{"br_taken", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0)});
                end
                1: begin
                    Ctrl_Branch = 1;
                    sb.push_back('{"br_not_taken", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)});
                end
                2: begin
                    Br_Taken = 1;
                    sb.push_back('{"no_branch_taken_hi", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)});
                end
                3: begin
                    Ctrl_Branch = 1; Br_Taken = 1; IdEx_RegWrite = 1; IdEx_Rd = 6; IfId_Rt = 6;
                    sb.push_back('{"br_alu_dep_stall", pk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0)});
                end
                default: begin
                    Ctrl_Branch = 1; Br_Taken = 1; IdEx_RegWrite = 1;
                    sb.push_back('{"br_r0_dep_no_stall", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0)});
                end
            endcase
            @(negedge CLK); e = sb.pop_front(); n_cmp++;
            if (obs !== e.v) begin
                n_mis++; $display("FAIL %s: got %b want %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_watchdog();
        exp_t e;
        for (int s = 0; s < 5; s++) begin
            @(posedge CLK); #1; clr();
            if (s < 3) begin
                IdEx_MemRead = 1; IdEx_RegWrite = 1; IdEx_Rd = 8; IfId_Rt = 8;
                sb.push_back('{"wd_stalling", pk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0)});
            end else begin
                sb.push_back('{"wd_err_sticky", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1)});
            end
            @(negedge CLK); e = sb.pop_front(); n_cmp++;
            if (obs !== e.v) begin
                n_mis++; $display("FAIL %s: got %b want %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        exp_t e;
        for (int s = 0; s < 3; s++) begin
            @(posedge CLK); #1; clr();
            case (s)
                0: begin
                    IdEx_MemRead = 1; IdEx_RegWrite = 1; IdEx_Rd = 3; IfId_Rs = 3; Ctrl_Branch = 1;
                    sb.push_back('{"rst_pre_stall", pk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1)});
                end
                1: begin
                    RST = 1;
                    IdEx_Rs = 5; ExMem_Rd = 5; ExMem_Reg_Wr_Control = 1;
                    IfId_Rt = 7; MemWb_Rd = 7; MemWb_Reg_Wr_Control = 1; Ctrl_Branch = 1;
                    sb.push_back('{"rst_mid_hold", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)});
                end
                default: begin
                    RST = 0;
                    sb.push_back('{"rst_back_to_idle", pk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)});
                end
            endcase
            @(negedge CLK); e = sb.pop_front(); n_cmp++;
            if (obs !== e.v) begin
                n_mis++; $display("FAIL %s: got %b want %b", e.name, obs, e.v);
            end
        end
    endtask

    initial begin
        RST = 1;
        clr();
        test_reset();
        test_ex_fwd();
        test_load_use();
        test_load_branch();
        test_branch();
        test_watchdog();
        test_reset_mid_hold();
        if (sb.size() != 0) begin
            n_cmp++; n_mis++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
